rice_encoder: RTL and testbench

Residual Rice encoder for the FLAC hardware path: the transmit-side counterpart of the Rice demapper. It accepts one signed 16-bit residual plus a 4-bit Rice parameter per handshake, zigzag-maps the residual to an unsigned value, and serialises the FLAC Rice code MSB-first as one bit per cycle: unary quotient zeros, a terminating one, then k remainder bits. It also presents the quotient/remainder split in parallel so a demapper can be driven directly for loopback checks.

---
 rtl/rice_pkg.sv | 21 ++
 rtl/rice_zigzag.sv | 23 ++
 rtl/rice_encoder.sv | 139 +++++++++++++
 tb/tb_rice_encoder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/rice_pkg.sv
// Shared types and helpers for the FLAC residual Rice encoder path:
// FSM state encoding, fixed widths and the signed-to-unsigned zigzag map.
package rice_pkg;

  localparam int DATA_W = 16;
  localparam int K_W    = 4;
  localparam int Q_W    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    UNARY = 2'd1,
    STOP  = 2'd2,
    REM   = 2'd3
  } riceState_e;

  // Two's complement residual to unsigned: 2d for d >= 0, -2d-1 for d < 0.
  function automatic logic [DATA_W-1:0] zigzag(input logic [DATA_W-1:0] d);
    return {d[DATA_W-2:0], 1'b0} ^ {DATA_W{d[DATA_W-1]}};
  endfunction

endpackage

// File: rtl/rice_zigzag.sv
// Combinational residual mapper: zigzag-maps a signed residual and splits the
// result into Rice quotient (u >> k) and remainder (low k bits of u).
module rice_zigzag
  import rice_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic [K_W-1:0]    riceParam,
  output logic [Q_W-1:0]    quot,
  output logic [Q_W-1:0]    rem
);

  logic [DATA_W-1:0] mapped_s;
  logic [DATA_W-1:0] mask_s;

  // Map and split; the mask is empty for k = 0 so the remainder is zero.
  always_comb begin
    mapped_s = zigzag(data);
    mask_s   = (16'd1 << riceParam) - 16'd1;
    quot     = mapped_s >> riceParam;
    rem      = mapped_s & mask_s;
  end

endmodule

// File: rtl/rice_encoder.sv
// Residual Rice encoder: accepts one residual per handshake and emits the
// FLAC Rice code MSB-first, one bit per downstream handshake.
module rice_encoder
  import rice_pkg::*;
(
  input  logic              iClk,
  input  logic              iRst,
  input  logic [DATA_W-1:0] iData,
  input  logic [K_W-1:0]    iRiceParam,
  input  logic              iValid,
  output logic              oReady,
  output logic              oBit,
  output logic              oBitValid,
  input  logic              iBitReady,
  output logic [Q_W-1:0]    oMSB,
  output logic [Q_W-1:0]    oLSB,
  output logic              oBusy
);

  riceState_e     state_r;
  logic [Q_W-1:0] cnt_r;
  logic [Q_W-1:0] msb_r;
  logic [Q_W-1:0] lsb_r;
  logic [K_W-1:0] k_r;
  logic [K_W-1:0] idx_r;
  logic           bit_r;
  logic           bitValid_r;
  logic           busy_r;
  logic           ready_r;
  logic [Q_W-1:0] quot_s;
  logic [Q_W-1:0] rem_s;

  rice_zigzag uZigzag (
    .data      (iData),
    .riceParam (iRiceParam),
    .quot      (quot_s),
    .rem       (rem_s)
  );

  // Ready is held low by reset itself so a same-cycle handshake is dropped.
  assign oReady    = ready_r & ~iRst;
  assign oBit      = bit_r;
  assign oBitValid = bitValid_r;
  assign oMSB      = msb_r;
  assign oLSB      = lsb_r;
  assign oBusy     = busy_r;

  // Code emission FSM; oBit is registered from the state being entered.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_r    <= IDLE;
      cnt_r      <= 16'd0;
      idx_r      <= 4'd0;
      k_r        <= 4'd0;
      msb_r      <= 16'd0;
      lsb_r      <= 16'd0;
      bit_r      <= 1'b0;
      bitValid_r <= 1'b0;
      busy_r     <= 1'b0;
      ready_r    <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (iValid && ready_r) begin
            k_r        <= iRiceParam;
            msb_r      <= quot_s;
            lsb_r      <= rem_s;
            cnt_r      <= quot_s;
            bitValid_r <= 1'b1;
            busy_r     <= 1'b1;
            ready_r    <= 1'b0;
            if (quot_s != 16'd0) begin
              state_r <= UNARY;
              bit_r   <= 1'b0;
            end else begin
              state_r <= STOP;
              bit_r   <= 1'b1;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        UNARY: begin
          if (iBitReady) begin
            cnt_r <= cnt_r - 16'd1;
            if (cnt_r == 16'd1) begin
              state_r <= STOP;
              bit_r   <= 1'b1;
            end else begin
              bit_r <= 1'b0;
            end
          end else begin
            state_r <= UNARY;
          end
        end
        STOP: begin
          if (iBitReady) begin
            if (k_r == 4'd0) begin
              state_r    <= IDLE;
              bit_r      <= 1'b0;
              bitValid_r <= 1'b0;
              busy_r     <= 1'b0;
              ready_r    <= 1'b1;
            end else begin
              state_r <= REM;
              idx_r   <= k_r - 4'd1;
              bit_r   <= lsb_r[k_r - 4'd1];
            end
          end else begin
            state_r <= STOP;
          end
        end
        REM: begin
          if (iBitReady) begin
            if (idx_r == 4'd0) begin
              state_r    <= IDLE;
              bit_r      <= 1'b0;
              bitValid_r <= 1'b0;
              busy_r     <= 1'b0;
              ready_r    <= 1'b1;
            end else begin
              idx_r <= idx_r - 4'd1;
              bit_r <= lsb_r[idx_r - 4'd1];
            end
          end else begin
            state_r <= REM;
          end
        end
        default: begin
          state_r    <= IDLE;
          bitValid_r <= 1'b0;
          busy_r     <= 1'b0;
          ready_r    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rice_encoder.sv
// Self-checking bench for rice_encoder: directed and randomized residuals
// compared against an arithmetic Rice-code model and a demapper loopback.
module tb_rice_encoder;

  logic        iClk = 1'b0;
  logic        iRst;
  logic [15:0] iData;
  logic [3:0]  iRiceParam;
  logic        iValid;
  logic        oReady;
  logic        oBit;
  logic        oBitValid;
  logic        iBitReady;
  logic [15:0] oMSB;
  logic [15:0] oLSB;
  logic        oBusy;

  int tests  = 0;
  int failed = 0;

  rice_encoder dut (
    .iClk       (iClk),
    .iRst       (iRst),
    .iData      (iData),
    .iRiceParam (iRiceParam),
    .iValid     (iValid),
    .oReady     (oReady),
    .oBit       (oBit),
    .oBitValid  (oBitValid),
    .iBitReady  (iBitReady),
    .oMSB       (oMSB),
    .oLSB       (oLSB),
    .oBusy      (oBusy)
  );

  always #5 iClk = ~iClk;

  // Called at a negedge with oReady expected high; returns at the negedge of
  // the idle bubble that follows the code, so consecutive calls run back-to-back.
  task automatic encode(input int d, input int k, input bit stall);
    int u, q, r, recon, dd, got, cyc, bitErr, stabErr, ctlErr;
    int expBits[$];
    bit prevStall;
    logic prevBit;
    u = (d >= 0) ? 2 * d : -2 * d - 1;
    q = u / (1 << k);
    r = u % (1 << k);
    expBits = {};
    for (int i = 0; i < q; i++) expBits.push_back(0);
    expBits.push_back(1);
    for (int i = k - 1; i >= 0; i--) expBits.push_back((r >> i) & 1);

    tests++;
    if (oReady !== 1'b1) begin
      failed++;
      $display("FAIL ready_before_accept d=%0d k=%0d: got %b want 1", d, k, oReady);
    end
    iValid = 1'b1;
    iData = d[15:0];
    iRiceParam = k[3:0];
    iBitReady = 1'b1;
    @(negedge iClk);
    iValid = 1'b0;

    tests++;
    if (oMSB !== q[15:0] || oLSB !== r[15:0]) begin
      failed++;
      $display("FAIL split d=%0d k=%0d: got msb=%0d lsb=%0d want msb=%0d lsb=%0d",
               d, k, oMSB, oLSB, q, r);
    end
    recon = (int'(oMSB) << k) | int'(oLSB);
    dd = (recon % 2 == 0) ? recon / 2 : -((recon + 1) / 2);
    tests++;
    if (dd != d) begin
      failed++;
      $display("FAIL loopback k=%0d: got d=%0d want d=%0d", k, dd, d);
    end

    got = 0; cyc = 0; bitErr = 0; stabErr = 0; ctlErr = 0; prevStall = 1'b0; prevBit = 1'b0;
    while (oBitValid === 1'b1 && cyc < 2000) begin
      if (oBusy !== 1'b1 || oReady !== 1'b0) ctlErr++;
      if (prevStall && oBit !== prevBit) stabErr++;
      iBitReady = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (iBitReady) begin
        if (got >= expBits.size() || oBit !== expBits[got][0]) bitErr++;
        got++;
      end
      prevStall = !iBitReady;
      prevBit = oBit;
      cyc++;
      @(negedge iClk);
    end
    iBitReady = 1'b1;

    tests++;
    if (cyc >= 2000) begin
      failed++;
      $display("FAIL timeout d=%0d k=%0d: code still running after %0d cycles", d, k, cyc);
    end
    tests++;
    if (bitErr != 0 || got != expBits.size()) begin
      failed++;
      $display("FAIL bits d=%0d k=%0d: %0d wrong bits, got %0d bits want %0d",
               d, k, bitErr, got, expBits.size());
    end
    tests++;
    if (stabErr != 0 || ctlErr != 0) begin
      failed++;
      $display("FAIL hold d=%0d k=%0d: %0d unstable stalls, %0d busy/ready errors want 0",
               d, k, stabErr, ctlErr);
    end
    if (!stall) begin
      tests++;
      if (cyc != expBits.size()) begin
        failed++;
        $display("FAIL cycles d=%0d k=%0d: got %0d want %0d", d, k, cyc, expBits.size());
      end
    end
    tests++;
    if (oReady !== 1'b1 || oBitValid !== 1'b0 || oBusy !== 1'b0) begin
      failed++;
      $display("FAIL bubble d=%0d k=%0d: got ready=%b valid=%b busy=%b want 1 0 0",
               d, k, oReady, oBitValid, oBusy);
    end
  endtask

  task automatic test_reset();
    iRst = 1'b1; iValid = 1'b1; iData = 16'd5; iRiceParam = 4'd0; iBitReady = 1'b1;
    repeat (2) @(negedge iClk);
    tests++;
    if (oReady !== 1'b0 || oBitValid !== 1'b0 || oBusy !== 1'b0 ||
        oMSB !== 16'd0 || oLSB !== 16'd0) begin
      failed++;
      $display("FAIL reset_state: got ready=%b valid=%b busy=%b msb=%0d lsb=%0d want 0 0 0 0 0",
               oReady, oBitValid, oBusy, oMSB, oLSB);
    end
    iRst = 1'b0; iValid = 1'b0;
    @(negedge iClk);
    tests++;
    if (oReady !== 1'b1 || oBitValid !== 1'b0) begin
      failed++;
      $display("FAIL reset_release: got ready=%b valid=%b want 1 0", oReady, oBitValid);
    end
  endtask

  task automatic test_basic();
    encode(1, 0, 1'b0);
    encode(-2, 3, 1'b0);
  endtask

  task automatic test_back_to_back();
    encode(50, 3, 1'b0);
    encode(-102, 3, 1'b0);
  endtask

  task automatic test_extremes();
    encode(-32768, 15, 1'b0);
    encode(32767, 15, 1'b0);
    encode(0, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    encode(7, 0, 1'b1);
    encode(-9, 2, 1'b1);
  endtask

  task automatic test_reset_mid();
    iValid = 1'b1; iData = 16'd50; iRiceParam = 4'd0; iBitReady = 1'b1;
    @(negedge iClk);
    iValid = 1'b0;
    repeat (4) @(negedge iClk);
    tests++;
    if (oBitValid !== 1'b1 || oBit !== 1'b0) begin
      failed++;
      $display("FAIL mid_unary: got valid=%b bit=%b want 1 0", oBitValid, oBit);
    end
    iRst = 1'b1; iValid = 1'b1;
    @(negedge iClk);
    tests++;
    if (oBitValid !== 1'b0 || oReady !== 1'b0 || oBusy !== 1'b0) begin
      failed++;
      $display("FAIL mid_reset: got valid=%b ready=%b busy=%b want 0 0 0",
               oBitValid, oReady, oBusy);
    end
    iRst = 1'b0; iValid = 1'b0;
    @(negedge iClk);
    tests++;
    if (oReady !== 1'b1 || oBitValid !== 1'b0) begin
      failed++;
      $display("FAIL mid_release: got ready=%b valid=%b want 1 0", oReady, oBitValid);
    end
    encode(1, 0, 1'b0);
  endtask

  task automatic test_random();
    int k, mag, d;
    for (int i = 0; i < 16; i++) begin
      k = $urandom_range(0, 15);
      mag = $urandom_range(0, 60) << k;
      if (mag > 32767) mag = 32767;
      d = ($urandom_range(0, 1) == 1) ? -mag : mag;
      encode(d, k, i[0]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_extremes();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
